// File: rtl/tiny_sequencer_pkg.sv
// Shared opcode constants, state encoding and PC wrap helper
// for the tiny sequencer and its datapath.
package tiny_sequencer_pkg;

  localparam logic [3:0] OP_HALT   = 4'b1111;
  localparam logic [3:0] OP_BRANCH = 4'b1000;
  localparam logic [3:0] OP_RET    = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_HALT,
    S_ERROR
  } seq_state_t;

  function automatic logic [7:0] pc_wrap(
    input int value,
    input int depth
  );
    return 8'(value % depth);
  endfunction

endpackage

// File: rtl/tiny_sequencer_timeout.sv
// WAIT-state watchdog: counts cycles while run is high and
// flags the last allowed cycle so the FSM can bail out.
module seq_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  assign expired = run && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tiny_sequencer.sv
// Fetch/decode/issue sequencer driving an external datapath
// through a one-cycle AluStart strobe and AluDone handshake.
module tiny_sequencer
  import tiny_sequencer_pkg::*;
#(
  parameter int PROG_DEPTH  = 20,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Start,
  input  logic [7:0] StartPC,
  output logic [7:0] ImemAddr,
  input  logic [7:0] ImemData,
  output logic       AluStart,
  output logic [3:0] AluOp,
  output logic [3:0] AluAddr,
  input  logic       AluDone,
  input  logic       CarryIn,
  output logic [7:0] PC,
  output logic       Busy,
  output logic       Halted,
  output logic       Error
);

  seq_state_t state;
  seq_state_t next_state;

  logic [7:0] pc;
  logic [7:0] next_pc;
  logic [7:0] ir;
  logic       issue;
  logic       wd_clear;
  logic       wd_run;
  logic       wd_expired;

  wire [3:0] opcode = ir[7:4];
  wire [3:0] target = ir[3:0];

  assign wd_clear = (state == S_EXEC);
  assign wd_run   = (state == S_WAIT) && !AluDone;

  seq_timeout_counter #(
    .LIMIT(ALU_TIMEOUT)
  ) u_watchdog (
    .clk    (Clock),
    .rst    (Reset),
    .clear  (wd_clear),
    .run    (wd_run),
    .expired(wd_expired)
  );

  always_comb begin
    next_state = state;
    next_pc    = pc;
    issue      = 1'b0;
    unique case (state)
      S_IDLE, S_HALT, S_ERROR: begin
        if (Start) begin
          next_pc    = pc_wrap(int'(StartPC), PROG_DEPTH);
          next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (Enable) next_state = S_DECODE;
      end
      S_DECODE: begin
        next_state = S_EXEC;
      end
      S_EXEC: begin
        unique case (opcode)
          OP_HALT: begin
            next_state = S_HALT;
          end
          OP_BRANCH: begin
            next_pc = CarryIn
              ? pc_wrap(int'(target), PROG_DEPTH)
              : pc_wrap(int'(pc) + 1, PROG_DEPTH);
            next_state = S_FETCH;
          end
          OP_RET: begin
            next_pc    = pc_wrap(int'(target), PROG_DEPTH);
            next_state = S_FETCH;
          end
          default: begin
            issue      = 1'b1;
            next_state = S_WAIT;
          end
        endcase
      end
      S_WAIT: begin
        // Enable is deliberately ignored so in-flight ops finish
        if (AluDone) begin
          next_pc    = pc_wrap(int'(pc) + 1, PROG_DEPTH);
          next_state = S_FETCH;
        end else if (wd_expired) begin
          next_state = S_ERROR;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      AluStart <= 1'b0;
      AluOp    <= '0;
      AluAddr  <= '0;
    end else begin
      state    <= next_state;
      pc       <= next_pc;
      AluStart <= issue;
      if (state == S_DECODE) ir <= ImemData;
      if (issue) begin
        AluOp   <= opcode;
        AluAddr <= target;
      end
    end
  end

  assign ImemAddr = pc;
  assign PC       = pc;
  assign Halted   = (state == S_HALT);
  assign Error    = (state == S_ERROR);
  assign Busy     = !(state == S_IDLE ||
                      state == S_HALT ||
                      state == S_ERROR);

endmodule

// File: tb/tb_tiny_sequencer.sv
// Directed bench for tiny_sequencer: issue, branch, halt,
// watchdog, wrap, stall, back-to-back and mid-WAIT reset.
module tb_tiny_sequencer;
  import tiny_sequencer_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Enable;
  logic       Start;
  logic [7:0] StartPC;
  logic [7:0] ImemAddr;
  logic [7:0] ImemData;
  logic       AluStart;
  logic [3:0] AluOp;
  logic [3:0] AluAddr;
  logic       AluDone;
  logic       CarryIn;
  logic [7:0] PC;
  logic       Busy;
  logic       Halted;
  logic       Error;

  logic [7:0] imem [0:255];
  int checks = 0;
  int failures = 0;
  int n_starts = 0;
  int base;

  tiny_sequencer #(
    .PROG_DEPTH (20),
    .ALU_TIMEOUT(16)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (Enable),
    .Start   (Start),
    .StartPC (StartPC),
    .ImemAddr(ImemAddr),
    .ImemData(ImemData),
    .AluStart(AluStart),
    .AluOp   (AluOp),
    .AluAddr (AluAddr),
    .AluDone (AluDone),
    .CarryIn (CarryIn),
    .PC      (PC),
    .Busy    (Busy),
    .Halted  (Halted),
    .Error   (Error)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) ImemData <= imem[ImemAddr];

  always @(posedge Clock)
    if (AluStart === 1'b1) n_starts <= n_starts + 1;

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic start_at(input logic [7:0] addr);
    StartPC = addr;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    checks++;
    if ({PC, ImemAddr, AluStart, AluOp, AluAddr,
         Busy, Halted, Error} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs got pc=%0d busy=%b halt=%b err=%b exp all 0",
               PC, Busy, Halted, Error);
    end
    checks++;
    if (dut.state !== S_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", dut.state, S_IDLE);
    end
    Reset = 1'b0;
    AluDone = 1'b1;
    step(2);
    AluDone = 1'b0;
    checks++;
    if (dut.state !== S_IDLE || Busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start got state=%0d busy=%b exp 0/0",
               dut.state, Busy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    imem[0] = 8'h10;
    base = n_starts;
    start_at(8'd0);
    checks++;
    if (dut.state !== S_FETCH || Busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_fetch got state=%0d busy=%b exp %0d/1",
               dut.state, Busy, S_FETCH);
    end
    step(3);
    checks++;
    if ({AluStart, AluOp, AluAddr} !== {1'b1, 4'd1, 4'd0}) begin
      failures++;
      $display("FAIL basic_issue got start=%b op=%0d addr=%0d exp 1/1/0",
               AluStart, AluOp, AluAddr);
    end
    tick();
    checks++;
    if (AluStart !== 1'b0 || dut.state !== S_WAIT) begin
      failures++;
      $display("FAIL basic_strobe_width got start=%b state=%0d exp 0/%0d",
               AluStart, dut.state, S_WAIT);
    end
    tick();
    AluDone = 1'b1;
    tick();
    AluDone = 1'b0;
    checks++;
    if (PC !== 8'd1 || dut.state !== S_FETCH) begin
      failures++;
      $display("FAIL basic_done got pc=%0d state=%0d exp 1/%0d",
               PC, dut.state, S_FETCH);
    end
    checks++;
    if (n_starts - base !== 1 || AluOp !== 4'd1) begin
      failures++;
      $display("FAIL basic_count got starts=%0d op=%0d exp 1/1",
               n_starts - base, AluOp);
    end
  endtask

  task automatic test_branch();
    do_reset();
    imem[0] = 8'h84;
    imem[2] = 8'h84;
    imem[3] = 8'hB7;
    base = n_starts;
    CarryIn = 1'b1;
    start_at(8'd0);
    step(3);
    checks++;
    if (PC !== 8'd4 || dut.state !== S_FETCH) begin
      failures++;
      $display("FAIL branch_taken got pc=%0d state=%0d exp 4/%0d",
               PC, dut.state, S_FETCH);
    end
    do_reset();
    CarryIn = 1'b0;
    start_at(8'd2);
    step(3);
    checks++;
    if (PC !== 8'd3) begin
      failures++;
      $display("FAIL branch_not_taken got pc=%0d exp 3", PC);
    end
    step(3);
    checks++;
    if (PC !== 8'd7) begin
      failures++;
      $display("FAIL ret_jump got pc=%0d exp 7", PC);
    end
    checks++;
    if (n_starts - base !== 0) begin
      failures++;
      $display("FAIL branch_no_issue got starts=%0d exp 0",
               n_starts - base);
    end
  endtask

  task automatic test_halt();
    do_reset();
    imem[6] = 8'hFF;
    imem[5] = 8'h10;
    start_at(8'd6);
    step(3);
    checks++;
    if ({Halted, Busy, PC} !== {1'b1, 1'b0, 8'd6}) begin
      failures++;
      $display("FAIL halt_enter got halt=%b busy=%b pc=%0d exp 1/0/6",
               Halted, Busy, PC);
    end
    AluDone = 1'b1;
    step(4);
    AluDone = 1'b0;
    checks++;
    if (Halted !== 1'b1 || PC !== 8'd6) begin
      failures++;
      $display("FAIL halt_sticky got halt=%b pc=%0d exp 1/6", Halted, PC);
    end
    start_at(8'd5);
    checks++;
    if (dut.state !== S_FETCH || PC !== 8'd5 || Halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_restart got state=%0d pc=%0d halt=%b exp %0d/5/0",
               dut.state, PC, Halted, S_FETCH);
    end
    start_at(8'd9);
    checks++;
    if (PC !== 8'd5 || dut.state !== S_DECODE) begin
      failures++;
      $display("FAIL start_while_busy got pc=%0d state=%0d exp 5/%0d",
               PC, dut.state, S_DECODE);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    imem[0] = 8'h23;
    imem[3] = 8'hB7;
    base = n_starts;
    start_at(8'd0);
    step(3);
    checks++;
    if (AluStart !== 1'b1 || AluOp !== 4'd2 || AluAddr !== 4'd3) begin
      failures++;
      $display("FAIL wd_issue got start=%b op=%0d addr=%0d exp 1/2/3",
               AluStart, AluOp, AluAddr);
    end
    step(15);
    checks++;
    if (Error !== 1'b0 || Busy !== 1'b1) begin
      failures++;
      $display("FAIL wd_early got err=%b busy=%b exp 0/1", Error, Busy);
    end
    tick();
    checks++;
    if (Error !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL wd_expire got err=%b busy=%b exp 1/0", Error, Busy);
    end
    step(3);
    checks++;
    if (Error !== 1'b1 || n_starts - base !== 1) begin
      failures++;
      $display("FAIL wd_sticky got err=%b starts=%0d exp 1/1",
               Error, n_starts - base);
    end
    start_at(8'd3);
    checks++;
    if (dut.state !== S_FETCH || PC !== 8'd3 || Error !== 1'b0) begin
      failures++;
      $display("FAIL wd_restart got state=%0d pc=%0d err=%b exp %0d/3/0",
               dut.state, PC, Error, S_FETCH);
    end
  endtask

  task automatic test_done_at_limit();
    do_reset();
    imem[0] = 8'h23;
    start_at(8'd0);
    step(3);
    step(15);
    AluDone = 1'b1;
    tick();
    AluDone = 1'b0;
    checks++;
    if (Error !== 1'b0 || PC !== 8'd1 || dut.state !== S_FETCH) begin
      failures++;
      $display("FAIL done_at_limit got err=%b pc=%0d state=%0d exp 0/1/%0d",
               Error, PC, dut.state, S_FETCH);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    imem[19] = 8'h35;
    start_at(8'd19);
    step(3);
    tick();
    AluDone = 1'b1;
    tick();
    AluDone = 1'b0;
    checks++;
    if (PC !== 8'd0 || dut.state !== S_FETCH) begin
      failures++;
      $display("FAIL pc_wrap got pc=%0d state=%0d exp 0/%0d",
               PC, dut.state, S_FETCH);
    end
    do_reset();
    start_at(8'd25);
    checks++;
    if (PC !== 8'd5) begin
      failures++;
      $display("FAIL startpc_wrap got pc=%0d exp 5", PC);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    imem[0] = 8'h12;
    imem[1] = 8'h34;
    imem[2] = 8'hFF;
    base = n_starts;
    start_at(8'd0);
    step(3);
    Enable = 1'b0;
    tick();
    AluDone = 1'b1;
    tick();
    AluDone = 1'b0;
    checks++;
    if (PC !== 8'd1 || dut.state !== S_FETCH) begin
      failures++;
      $display("FAIL wait_ignores_enable got pc=%0d state=%0d exp 1/%0d",
               PC, dut.state, S_FETCH);
    end
    tick();
    Enable = 1'b1;
    step(3);
    checks++;
    if ({AluStart, AluOp, AluAddr} !== {1'b1, 4'd3, 4'd4}) begin
      failures++;
      $display("FAIL b2b_issue got start=%b op=%0d addr=%0d exp 1/3/4",
               AluStart, AluOp, AluAddr);
    end
    AluDone = 1'b1;
    tick();
    AluDone = 1'b0;
    step(3);
    checks++;
    if (Halted !== 1'b1 || PC !== 8'd2 || n_starts - base !== 2) begin
      failures++;
      $display("FAIL b2b_halt got halt=%b pc=%0d starts=%0d exp 1/2/2",
               Halted, PC, n_starts - base);
    end
  endtask

  task automatic test_stall_reset();
    do_reset();
    imem[0] = 8'h10;
    base = n_starts;
    Enable = 1'b0;
    start_at(8'd0);
    step(5);
    checks++;
    if (dut.state !== S_FETCH || PC !== 8'd0) begin
      failures++;
      $display("FAIL stall_hold got state=%0d pc=%0d exp %0d/0",
               dut.state, PC, S_FETCH);
    end
    Enable = 1'b1;
    tick();
    checks++;
    if (dut.state !== S_DECODE) begin
      failures++;
      $display("FAIL stall_release got state=%0d exp %0d",
               dut.state, S_DECODE);
    end
    step(2);
    tick();
    Reset = 1'b1;
    #1;
    checks++;
    if ({PC, ImemAddr, AluStart, AluOp, AluAddr,
         Busy, Halted, Error} !== 27'd0 || dut.state !== S_IDLE) begin
      failures++;
      $display("FAIL wait_reset got pc=%0d op=%0d busy=%b state=%0d exp 0",
               PC, AluOp, Busy, dut.state);
    end
    tick();
    Reset = 1'b0;
    AluDone = 1'b1;
    step(2);
    AluDone = 1'b0;
    checks++;
    if (dut.state !== S_IDLE || PC !== 8'd0 || n_starts - base !== 1) begin
      failures++;
      $display("FAIL late_done got state=%0d pc=%0d starts=%0d exp %0d/0/1",
               dut.state, PC, n_starts - base, S_IDLE);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    Reset = 1'b1;
    Enable = 1'b1;
    Start = 1'b0;
    StartPC = 8'd0;
    AluDone = 1'b0;
    CarryIn = 1'b0;
    test_reset();
    test_basic();
    test_branch();
    test_halt();
    test_watchdog();
    test_done_at_limit();
    test_wrap();
    test_back_to_back();
    test_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tiny_sequencer.md
TINY_SEQUENCER -- requirements
Module: tiny_sequencer

Interface
REQ-001 Parameter PROG_DEPTH, default 20: number of instruction-memory words; PC wraps modulo PROG_DEPTH.
REQ-002 Parameter ALU_TIMEOUT, default 16: maximum number of cycles to wait for AluDone.
REQ-003 Port Clock, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port Enable, input, 1 bit: run permission; low stalls fetch and issue.
REQ-006 Port Start, input, 1 bit: one-cycle pulse that begins execution from StartPC.
REQ-007 Port StartPC, input, 8 bits: entry address, sampled on Start.
REQ-008 Port ImemAddr, output, 8 bits: instruction-memory read address.
REQ-009 Port ImemData, input, 8 bits: instruction word, valid one cycle after ImemAddr.
REQ-010 Port AluStart, output, 1 bit: one-cycle datapath issue strobe.
REQ-011 Port AluOp, output, 4 bits: Instruction[7:4], held from issue until done.
REQ-012 Port AluAddr, output, 4 bits: Instruction[3:0], held from issue until done.
REQ-013 Port AluDone, input, 1 bit: datapath completion pulse.
REQ-014 Port CarryIn, input, 1 bit: datapath carry/borrow flag.
REQ-015 Port PC, output, 8 bits: current program counter.
REQ-016 Port Busy, output, 1 bit: high in every state except IDLE, HALT and ERROR.
REQ-017 Port Halted, output, 1 bit: high in HALT.
REQ-018 Port Error, output, 1 bit: high in ERROR.

Function
REQ-019 States: IDLE, FETCH, DECODE, EXEC, WAIT, HALT, ERROR.
REQ-020 IDLE: Start=1 loads PC=StartPC mod PROG_DEPTH and goes to FETCH; other inputs are ignored.
REQ-021 FETCH: ImemAddr=PC; with Enable=1 advance to DECODE next cycle; with Enable=0 hold.
REQ-022 DECODE: latch ImemData into the instruction register, then go to EXEC.
REQ-023 EXEC, opcode 1111: go to HALT; PC unchanged.
REQ-024 EXEC, opcode 1000: if CarryIn=1 then PC=Address, else PC=PC+1; go to FETCH; no AluStart.
REQ-025 EXEC, opcode 1011: PC=Address unconditionally; go to FETCH; no AluStart.
REQ-026 EXEC, all other opcodes: pulse AluStart for exactly one cycle, go to WAIT, clear the timeout counter.
REQ-027 WAIT: AluDone=1 sets PC=PC+1 and goes to FETCH; Enable is ignored in WAIT so in-flight ops complete.
REQ-028 WAIT: after ALU_TIMEOUT cycles without AluDone, go to ERROR.
REQ-029 AluDone arriving in any state other than WAIT is ignored.
REQ-030 PC increment and branch targets wrap modulo PROG_DEPTH; a target of PROG_DEPTH or more wraps as well.
REQ-031 Instruction-fetch latency is 3 cycles (FETCH, DECODE, EXEC) plus the datapath latency.
REQ-032 HALT and ERROR are sticky; only Start (restarting from StartPC) or Reset leaves them.
REQ-033 Start asserted while Busy is ignored.

Reset
REQ-034 Reset=1 immediately forces: state=IDLE, PC=0, ImemAddr=0, AluStart=0, AluOp=0, AluAddr=0, Busy=0, Halted=0, Error=0, timeout counter=0.
REQ-035 Reset asserted mid-operation, including during WAIT, aborts without emitting any further AluStart; after release the block waits for Start.

Structure
REQ-036 A shared package holds the opcode constants (HALT=4'b1111, BRANCH=4'b1000, RET=4'b1011) and the state enumeration, for reuse by the datapath.
REQ-037 The block is a single module; one sub-module, seq_timeout_counter, holds the WAIT watchdog.

Verification
REQ-038 Basic issue: StartPC=0, ImemData[0]=8'h10, AluDone two cycles after AluStart -> exactly one AluStart, AluOp=1, AluAddr=0, then PC=1 and state FETCH.
REQ-039 Branch taken/not taken: instruction 8'h84 with CarryIn=1 -> PC=4, no AluStart; with CarryIn=0 -> PC=PC+1.
REQ-040 Halt: instruction 8'hFF -> Halted=1 and Busy=0 with PC unchanged; Start with StartPC=5 -> FETCH at PC=5.
REQ-041 Watchdog: ALU_TIMEOUT=16 and AluDone never asserted -> Error=1 sixteen cycles after AluStart; a later Start restarts execution.
REQ-042 Wrap: PC=19 with PROG_DEPTH=20 and a normal op completing -> PC=0.
REQ-043 Stall and reset: Enable=0 in FETCH holds the state for 5 cycles; Reset pulsed in WAIT -> all outputs 0 and state IDLE the same cycle; a late AluDone is ignored.
